rsp_mult_arb: RTL and testbench
===============================

# rsp_mult_arb

Round-robin arbiter and sequencer that shares one pipelined signed/unsigned multiplier (fixed latency DELAY, truncated P_width-bit product) among N_REQ requesters. It accepts operand requests over valid/ready handshakes and issues at most one operation per cycle. A tag pipeline tracks each operation so its result returns to the requester that issued it. The block sits between the preprocessing stage-1 clients and the shared multiplier instance.

## Interface
- N_REQ, 4, number of requesters (2..8)
- DELAY, 2, multiplier pipeline depth in cycles (≥1, equal to the multiplier's DELAY)
- A_width, 8, operand A width
- B_width, 8, operand B width
- P_width, 15, returned product width
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- EN  in  1  run enable
- REQ_VALID  in  N_REQ  per-requester request valid
- REQ_READY  out  N_REQ  per-requester grant, at most one bit high
- REQ_A  in  N_REQ*A_width  packed operand A, requester i at [i*A_width +: A_width]
- REQ_B  in  N_REQ*B_width  packed operand B
- REQ_TC  in  N_REQ  per-requester mode: 0 unsigned, 1 signed
- MULT_A  out  A_width  registered operand A to the multiplier
- MULT_B  out  B_width  registered operand B
- MULT_TC  out  1  registered mode
- MULT_P  in  P_width  multiplier PRODUCT
- RSP_VALID  out  N_REQ  one-hot result strobe, no backpressure
- RSP_P  out  P_width  result, shared by all requesters
- IDLE  out  1  high in IDLE state

## Operation
- FSM states:
  - IDLE → RUN when EN=1.
  - RUN → DRAIN when EN=0.
  - DRAIN → RUN when EN=1.
  - DRAIN → IDLE when in-flight count is 0 and EN=0.
- Grant is combinational. REQ_READY is the round-robin winner among REQ_VALID, and only when state=RUN and EN=1; otherwise it is 0.
- Priority pointer ptr:
  - Search order is ptr, ptr+1, …, wrapping mod N_REQ.
  - On a handshake by requester i, ptr ← (i+1) mod N_REQ.
  - No handshake leaves ptr unchanged.
- On a handshake, MULT_A/B/TC register the winner's operands, and tag {valid, index} enters tag pipeline stage 0.
- With no handshake, MULT_A/B/TC hold their values and a null tag (valid=0) enters stage 0.
- The tag pipeline is DELAY+1 stages deep. When the last stage holds a valid tag:
  - RSP_P ← MULT_P.
  - RSP_VALID ← one-hot(index).
  - Otherwise RSP_VALID ← 0 and RSP_P holds its value.
- In-flight counter, width clog2(DELAY+2):
  - +1 on a handshake.
  - −1 on a response.
  - Unchanged when both happen in the same cycle.
- DRAIN delivers every outstanding result and issues nothing new.
- A requester holding REQ_VALID with no grant must keep its operands stable. Dropping REQ_VALID before a grant is legal.

## Timing
- Reset values:
  - REQ_READY=0, RSP_VALID=0.
  - RSP_P=0, MULT_A=0, MULT_B=0, MULT_TC=0.
  - IDLE=1, ptr=0, all tags invalid, count=0, state IDLE.
- An EN rising edge sampled at edge t gives RUN from t, so REQ_READY can be high in the cycle after t.
- Latency: a handshake at edge t gives RSP_VALID high for exactly the one cycle following edge t+DELAY+1.
- Throughput is one operation per cycle, back-to-back, from any mix of requesters.
- EN falling mid-burst: REQ_READY drops combinationally in the same cycle. Already-accepted operations still return at their normal latency.
- Reset asserted mid-operation discards all in-flight operations. No RSP_VALID is produced for them after reset releases.

## Configuration
- RSP_MULT_ARB_PERF_EN defined:
  - Adds output PERF_CNT (N_REQ*16 bits): one saturating 16-bit handshake counter per requester.
  - Counters clear on reset and hold at 16'hFFFF.
- Macro undefined: no port, no counters. All other behaviour is identical.

## Structure
- Shared package rsp_mult_pkg holds:
  - FSM state encoding (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2).
  - Tag field layout.
  - A clog2 constant function.
- One sub-module, rsp_rr_arb:
  - Parameterised N_REQ.
  - Combinational one-hot winner from a request vector and pointer.
  - Registered pointer update on an accept strobe.
- The multiplier is instantiated outside this block. The bench instantiates both blocks together with matching DELAY.

## Test plan
- Single op: DELAY=2, requester 2 sends A=8'hFD (−3), B=8'h05, TC=1 → REQ_READY[2] same cycle; 3 cycles later RSP_VALID=4'b0100, RSP_P = bits [15:1] of 16'hFFF1 (15'h7FF8).
- Fairness: all four requesters hold REQ_VALID for 8 cycles starting with ptr=0 → grant order 0,1,2,3,0,1,2,3; responses arrive in the same order on consecutive cycles.
- Drain: EN drops while 3 ops are in flight → REQ_READY=0 at once; 3 responses still delivered; IDLE rises in the cycle after the last response.
- Reset mid-burst: RST_N pulsed low with 2 ops in flight → all outputs return to reset values; no RSP_VALID after release until new requests are granted.
- Unsigned mode: A=8'hFF, B=8'hFF, TC=0 → RSP_P = bits [15:1] of 16'hFE01 = 15'h7F00.
- PERF (with RSP_MULT_ARB_PERF_EN): requester 1 sends 70000 handshakes → PERF_CNT[31:16]=16'hFFFF.

Source files
------------

// File: rtl/rsp_mult_pkg.sv
// rsp_mult_pkg: shared FSM encoding, tag layout and clog2 helper for rsp_mult_arb.
package rsp_mult_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
    localparam int TAG_IDX_W = 3;
    typedef struct packed {
        logic                 vld;
        logic [TAG_IDX_W-1:0] idx;
    } tag_t;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/rsp_rr_arb.sv
// rsp_rr_arb: combinational round-robin winner with registered priority pointer.
module rsp_rr_arb
    import rsp_mult_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int PW = clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             accept,
    output logic [N_REQ-1:0] gnt,
    output logic [PW-1:0]    idx
);
    logic [PW-1:0] ptr;
    logic          hit;

    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!hit && req[(int'(ptr) + k) % N_REQ]) begin
                hit = 1'b1;
                idx = PW'((int'(ptr) + k) % N_REQ);
            end
        end
        gnt = hit ? (N_REQ'(1) << idx) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr <= '0;
        else if (accept) ptr <= (int'(idx) == N_REQ - 1) ? '0 : idx + PW'(1);
    end
endmodule

// File: rtl/rsp_mult_arb.sv
// rsp_mult_arb: shares one pipelined multiplier among N_REQ requesters with tagged return.
// Optional RSP_MULT_ARB_PERF_EN adds per-requester saturating handshake counters.
module rsp_mult_arb
    import rsp_mult_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DELAY   = 2,
    parameter int A_width = 8,
    parameter int B_width = 8,
    parameter int P_width = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*A_width-1:0] req_a,
    input  logic [N_REQ*B_width-1:0] req_b,
    input  logic [N_REQ-1:0]         req_tc,
    output logic [A_width-1:0]       mult_a,
    output logic [B_width-1:0]       mult_b,
    output logic                     mult_tc,
    input  logic [P_width-1:0]       mult_p,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [P_width-1:0]       rsp_p,
`ifdef RSP_MULT_ARB_PERF_EN
    output logic [N_REQ*16-1:0]      perf_cnt,
`endif
    output logic                     idle
);
    localparam int CW = clog2(DELAY + 2);

    state_t                    state, state_nx;
    logic [N_REQ-1:0]          gnt;
    logic [clog2(N_REQ)-1:0]   win;
    logic                      hs, done;
    logic [CW-1:0]             cnt;
    tag_t                      tags [DELAY+1];

    rsp_rr_arb #(.N_REQ(N_REQ)) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ((state == RUN && en) ? req_valid : '0),
        .accept (hs),
        .gnt    (gnt),
        .idx    (win)
    );

    assign req_ready = gnt;
    assign hs        = |gnt;
    assign done      = tags[DELAY].vld;
    assign idle      = state == IDLE;

    always_comb begin
        state_nx = state == IDLE ? (en ? RUN : IDLE)
                 : state == RUN  ? (en ? RUN : DRAIN)
                 : en ? RUN : (cnt == '0 ? IDLE : DRAIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end

    // Tags travel alongside the multiplier so each product returns to its issuer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mult_a    <= '0;
            mult_b    <= '0;
            mult_tc   <= 1'b0;
            rsp_valid <= '0;
            rsp_p     <= '0;
            cnt       <= '0;
            for (int k = 0; k <= DELAY; k++) tags[k] <= '0;
        end else begin
            if (hs) begin
                mult_a  <= req_a[win*A_width +: A_width];
                mult_b  <= req_b[win*B_width +: B_width];
                mult_tc <= req_tc[win];
            end
            tags[0] <= hs ? '{vld: 1'b1, idx: TAG_IDX_W'(win)} : '0;
            for (int k = 1; k <= DELAY; k++) tags[k] <= tags[k-1];
            rsp_valid <= done ? (N_REQ'(1) << tags[DELAY].idx) : '0;
            if (done) rsp_p <= mult_p;
            cnt <= (hs && !done) ? cnt + CW'(1) : (done && !hs) ? cnt - CW'(1) : cnt;
        end
    end

`ifdef RSP_MULT_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) perf_cnt <= '0;
        else
            for (int i = 0; i < N_REQ; i++)
                if (gnt[i] && perf_cnt[i*16 +: 16] != 16'hFFFF)
                    perf_cnt[i*16 +: 16] <= perf_cnt[i*16 +: 16] + 16'd1;
    end
`endif
endmodule

// File: tb/tb_rsp_mult_arb.sv
// tb_rsp_mult_arb: directed + random stimulus against a queue-based reference model.
module tb_rsp_mult_arb;
    localparam int N = 4;
    localparam int DELAY = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [31:0]  req_a = '0;
    logic [31:0]  req_b = '0;
    logic [3:0]   req_tc = '0;
    logic [7:0]   mult_a, mult_b;
    logic         mult_tc;
    logic [14:0]  mult_p;
    logic [3:0]   rsp_valid;
    logic [14:0]  rsp_p;
    logic         idle;
`ifdef RSP_MULT_ARB_PERF_EN
    logic [63:0]  perf_cnt;
`endif

    always #5 clk = ~clk;

    rsp_mult_arb #(.N_REQ(N), .DELAY(DELAY), .A_width(8), .B_width(8), .P_width(15)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_tc(req_tc),
        .mult_a(mult_a), .mult_b(mult_b), .mult_tc(mult_tc), .mult_p(mult_p),
        .rsp_valid(rsp_valid), .rsp_p(rsp_p),
`ifdef RSP_MULT_ARB_PERF_EN
        .perf_cnt(perf_cnt),
`endif
        .idle(idle)
    );

    // Stand-in for the shared multiplier: DELAY-stage pipe of the truncated product.
    logic [15:0] full;
    logic [14:0] pipe [DELAY];
    assign full   = {{8{mult_tc & mult_a[7]}}, mult_a} * {{8{mult_tc & mult_b[7]}}, mult_b};
    assign mult_p = pipe[DELAY-1];
    always_ff @(posedge clk) begin
        pipe[0] <= full[15:1];
        for (int k = 1; k < DELAY; k++) pipe[k] <= pipe[k-1];
    end

    typedef struct {int due; int idx; logic [14:0] p;} exp_t;
    exp_t        q[$];
    int          gnt_log[$], rsp_log[$], rsp_cyc[$];
    int          errors = 0, checks = 0;
    int          cyc = 0, mst = 0, ptr = 0, mc = 0;
    int          hs_cnt[N];
    logic [14:0] last_p = '0;
    logic [3:0]  last_gnt = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] ref_prod(input logic [7:0] a, input logic [7:0] b, input logic tc);
        int p;
        p = tc ? int'($signed(a)) * int'($signed(b)) : int'(a) * int'(b);
        return p[15:1];
    endfunction

    task automatic model_reset();
        q.delete();
        mst = 0; ptr = 0; mc = 0; last_p = '0; last_gnt = '0;
        for (int i = 0; i < N; i++) hs_cnt[i] = 0;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic tc);
        req_valid[i] = 1'b1;
        req_a[i*8 +: 8] = a;
        req_b[i*8 +: 8] = b;
        req_tc[i] = tc;
    endtask

    // One clock of stimulus: check grant mid-cycle, then outputs just after the edge.
    task automatic step();
        logic [3:0] eg;
        int w, nst;
        bit resp;
        exp_t e;
        eg = '0; w = -1;
        if (mst == 1 && en)
            for (int k = 0; k < N; k++)
                if (w < 0 && req_valid[(ptr + k) % N]) w = (ptr + k) % N;
        if (w >= 0) eg[w] = 1'b1;
        @(negedge clk);
        chk("req_ready", req_ready, eg);
        if (w >= 0) begin
            q.push_back('{cyc + DELAY + 2, w, ref_prod(req_a[w*8 +: 8], req_b[w*8 +: 8], req_tc[w])});
            gnt_log.push_back(w);
            hs_cnt[w]++;
            ptr = (w + 1) % N;
        end
        nst = mst == 0 ? (en ? 1 : 0) : mst == 1 ? (en ? 1 : 2) : en ? 1 : (mc == 0 ? 0 : 2);
        @(posedge clk);
        cyc++;
        #1;
        resp = q.size() > 0 && q[0].due == cyc;
        mc = mc + int'(w >= 0) - int'(resp);
        mst = nst;
        if (resp) begin
            e = q.pop_front();
            chk("rsp_valid", rsp_valid, 32'(1) << e.idx);
            chk("rsp_p", rsp_p, e.p);
            last_p = e.p;
            rsp_log.push_back(e.idx);
            rsp_cyc.push_back(cyc);
        end else begin
            chk("rsp_valid_idle", rsp_valid, 0);
            chk("rsp_p_hold", rsp_p, last_p);
        end
        chk("idle", idle, mst == 0);
        last_gnt = eg;
    endtask

    initial begin
        int n, last_rsp, idle_cyc;
        model_reset();
        #12;
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_p", rsp_p, 0);
        chk("rst_mult_a", mult_a, 0);
        chk("rst_mult_b", mult_b, 0);
        chk("rst_mult_tc", mult_tc, 0);
        chk("rst_idle", idle, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single signed op from requester 2
        en = 1'b1;
        step();
        set_req(2, 8'hFD, 8'h05, 1'b1);
        step();
        req_valid = '0;
        repeat (4) step();
        chk("single_p", rsp_p, 15'h7FF8);
        chk("single_idx", rsp_log[rsp_log.size()-1], 2);

        // Unsigned op from requester 3 (leaves pointer at 0)
        set_req(3, 8'hFF, 8'hFF, 1'b0);
        step();
        req_valid = '0;
        repeat (4) step();
        chk("unsigned_p", rsp_p, 15'h7F00);

        // Fairness: all four hold valid for 8 cycles
        gnt_log.delete(); rsp_log.delete(); rsp_cyc.delete();
        for (int i = 0; i < N; i++) set_req(i, 8'(8'h11 * (i + 1)), 8'(8'h80 + i), i[0]);
        repeat (8) step();
        req_valid = '0;
        repeat (5) step();
        for (int k = 0; k < 8; k++) begin
            chk("fair_gnt", gnt_log[k], k % 4);
            chk("fair_rsp", rsp_log[k], k % 4);
            if (k > 0) chk("fair_b2b", rsp_cyc[k] - rsp_cyc[k-1], 1);
        end

        // Random traffic; pending requesters keep operands stable
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++)
                if (!(req_valid[i] && !last_gnt[i])) begin
                    req_valid[i] = $urandom_range(0, 2) != 0;
                    req_a[i*8 +: 8] = 8'($urandom);
                    req_b[i*8 +: 8] = 8'($urandom);
                    req_tc[i] = 1'($urandom);
                end
            en = $urandom_range(0, 15) != 0;
            step();
        end

        // Drain with 3 ops in flight
        en = 1'b1; req_valid = '0;
        repeat (6) step();
        req_valid = 4'hF;
        repeat (3) step();
        en = 1'b0;
        #1;
        chk("drain_ready_now", req_ready, 0);
        n = 0; last_rsp = -1; idle_cyc = -1;
        for (int k = 0; k < 10 && idle_cyc < 0; k++) begin
            step();
            if (rsp_valid != 0) begin n++; last_rsp = cyc; end
            if (idle) idle_cyc = cyc;
        end
        chk("drain_count", n, 3);
        chk("drain_idle_timing", idle_cyc - last_rsp, 1);

        // Reset mid-burst with 2 ops in flight
        en = 1'b1; req_valid = 4'hF;
        repeat (3) step();
        chk("pre_reset_inflight", mc, 2);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_rsp_p", rsp_p, 0);
        chk("mid_rst_mult_a", mult_a, 0);
        chk("mid_rst_mult_b", mult_b, 0);
        chk("mid_rst_mult_tc", mult_tc, 0);
        chk("mid_rst_idle", idle, 1);
        model_reset();
        rst_n = 1'b1;
        req_valid = '0;
        repeat (6) step();
        req_valid = 4'hF;
        gnt_log.delete();
        repeat (2) step();
        chk("post_rst_first_gnt", gnt_log[0], 0);
        req_valid = '0;
        repeat (5) step();

`ifdef RSP_MULT_ARB_PERF_EN
        @(negedge clk);
        for (int i = 0; i < N; i++) chk("perf_model", perf_cnt[i*16 +: 16], 16'(hs_cnt[i]));
        en = 1'b1; req_valid = 4'b0010;
        repeat (70000) @(posedge clk);
        @(negedge clk);
        chk("perf_sat", perf_cnt[31:16], 16'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
